// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  localparam logic TX_IDLE_LVL = 1'b1;

  // Busy cycles in one frame; p is 1 when a parity bit is sent.
  function automatic int frame_clks(input int data_w, input int clks_per_bit,
                                    input int stop_bits, input int p);
    return (1 + data_w + p + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Word handshake between a data source and the UART transmitter.
// parity_odd is present only when UART_TX_PARITY_EN is defined.
interface uart_tx_param_if #(parameter int DATA_W = 8);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
`ifdef UART_TX_PARITY_EN
  logic              parity_odd;

  modport master (output tx_data, tx_valid, parity_odd, input tx_ready);
  modport slave  (input tx_data, tx_valid, parity_odd, output tx_ready);
`else
  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave  (input tx_data, tx_valid, output tx_ready);
`endif

endinterface

// File: rtl/uart_tx_param_baud_cnt.sv
// Bit-period counter: bit_done pulses in the last clk of each serial bit.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_done = en && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready word input and back-to-back frames.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
//
// state  | meaning
// IDLE   | line high, waiting for a word
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit (UART_TX_PARITY_EN only)
// STOP   | stop bit(s), line high
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_param_if.slave   s_if,
  output logic             tx,
  output logic             busy
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              stop_q, stop_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              bit_done;
  logic              accept;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .en       (state_q != IDLE),
    .bit_done (bit_done)
  );

  // Ready also in the final stop cycle so the next start bit follows with no gap.
  assign s_if.tx_ready = (state_q == IDLE) ||
                         ((state_q == STOP) && (stop_q == STOP_LAST) && bit_done);
  assign accept = s_if.tx_valid && s_if.tx_ready;
  assign tx     = tx_q;
  assign busy   = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      tx_q    <= TX_IDLE_LVL;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    data_d  = data_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      state_d = START;
      idx_d   = '0;
      stop_d  = 1'b0;
      data_d  = s_if.tx_data;
`ifdef UART_TX_PARITY_EN
      par_d   = s_if.parity_odd;
`endif
    end else begin
      case (state_q)
        START: if (bit_done) state_d = DATA;
        DATA: begin
          if (bit_done) begin
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        PARITY: if (bit_done) state_d = STOP;
        STOP: begin
          if (bit_done) begin
            if (stop_q == STOP_LAST) state_d = IDLE;
            else                     stop_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Line level is derived from the next state so tx stays aligned with state_q.
  always_comb begin
    tx_d   = TX_IDLE_LVL;
    busy_d = (state_d != IDLE);
    case (state_d)
      START: tx_d = 1'b0;
      DATA:  tx_d = data_d[idx_d];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = (^data_d) ^ par_d;
`endif
      default: tx_d = TX_IDLE_LVL;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: 8-bit/1-stop and 5-bit/2-stop instances.
`timescale 1ns/1ps
module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  uart_tx_param_if #(.DATA_W(8)) if0 ();
  uart_tx_param_if #(.DATA_W(5)) if1 ();
  logic tx0, busy0, tx1, busy1;

  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_if(if0), .tx(tx0), .busy(busy0));

  uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(4), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_if(if1), .tx(tx1), .busy(busy1));

  task automatic test_reset();
    #12;
    n_vec++; if (tx0 !== 1'b1) begin $display("FAIL reset_tx0 got %b want 1", tx0); n_miss++; end
    n_vec++; if (busy0 !== 1'b0) begin $display("FAIL reset_busy0 got %b want 0", busy0); n_miss++; end
    n_vec++; if (tx1 !== 1'b1) begin $display("FAIL reset_tx1 got %b want 1", tx1); n_miss++; end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++; if (if0.tx_ready !== 1'b1) begin $display("FAIL reset_ready got %b want 1", if0.tx_ready); n_miss++; end
    n_vec++; if (if1.tx_ready !== 1'b1) begin $display("FAIL reset_ready1 got %b want 1", if1.tx_ready); n_miss++; end
  endtask

  task automatic test_basic(input logic [7:0] d, input string nm);
    logic [15:0] exp;
    int busy_n, rdy_low, fl;
    exp = {6'h3F, (P == 1) ? 1'b0 : 1'b1, d, 1'b0};
    fl = 40 + 4 * P;
    busy_n = 0;
    rdy_low = 0;
    @(negedge clk);
    if0.tx_data = d;
    if0.tx_valid = 1'b1;
    @(negedge clk);
    if0.tx_valid = 1'b0;
    for (int k = 0; k < fl + 8; k++) begin
      n_vec++;
      if (tx0 !== exp[k/4]) begin
        $display("FAIL %s_tx cycle %0d got %b want %b", nm, k, tx0, exp[k/4]); n_miss++;
      end
      if (busy0) busy_n++;
      if (!if0.tx_ready) rdy_low++;
      @(negedge clk);
    end
    n_vec++; if (busy_n != fl) begin $display("FAIL %s_busy_len got %0d want %0d", nm, busy_n, fl); n_miss++; end
    n_vec++; if (rdy_low != fl - 1) begin $display("FAIL %s_ready_low got %0d want %0d", nm, rdy_low, fl - 1); n_miss++; end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp1, exp2;
    int busy_n, fl;
    logic want;
    exp1 = {6'h3F, (P == 1) ? 1'b0 : 1'b1, 8'h00, 1'b0};
    exp2 = {6'h3F, (P == 1) ? 1'b0 : 1'b1, 8'hFF, 1'b0};
    fl = 40 + 4 * P;
    busy_n = 0;
    @(negedge clk);
    if0.tx_data = 8'h00;
    if0.tx_valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2 * fl + 8; k++) begin
      want = (k < fl) ? exp1[k/4] : exp2[(k - fl)/4];
      n_vec++;
      if (tx0 !== want) begin $display("FAIL b2b_tx cycle %0d got %b want %b", k, tx0, want); n_miss++; end
      if (k < 2 * fl) begin
        n_vec++;
        if (busy0 !== 1'b1) begin $display("FAIL b2b_busy cycle %0d got %b want 1", k, busy0); n_miss++; end
      end
      if (busy0) busy_n++;
      if (k == 0) if0.tx_data = 8'hFF;
      if (k == fl) if0.tx_valid = 1'b0;
      @(negedge clk);
    end
    n_vec++; if (busy_n != 2 * fl) begin $display("FAIL b2b_busy_len got %0d want %0d", busy_n, 2 * fl); n_miss++; end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    if0.tx_data = 8'h5A;
    if0.tx_valid = 1'b1;
    @(negedge clk);
    if0.tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    n_vec++; if (busy0 !== 1'b1) begin $display("FAIL rstmid_pre_busy got %b want 1", busy0); n_miss++; end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (tx0 !== 1'b1) begin $display("FAIL rstmid_tx got %b want 1", tx0); n_miss++; end
    n_vec++; if (busy0 !== 1'b0) begin $display("FAIL rstmid_busy got %b want 0", busy0); n_miss++; end
    n_vec++; if (if0.tx_ready !== 1'b1) begin $display("FAIL rstmid_ready got %b want 1", if0.tx_ready); n_miss++; end
    @(negedge clk);
    rst_n = 1'b1;
    test_basic(8'h3C, "after_rst");
  endtask

  task automatic test_ignore_busy();
    logic [15:0] exp;
    int busy_n, fl;
    exp = {6'h3F, (P == 1) ? 1'b0 : 1'b1, 8'hC3, 1'b0};
    fl = 40 + 4 * P;
    busy_n = 0;
    @(negedge clk);
    if0.tx_data = 8'hC3;
    if0.tx_valid = 1'b1;
    @(negedge clk);
    if0.tx_valid = 1'b0;
    for (int k = 0; k < fl + 20; k++) begin
      n_vec++;
      if (tx0 !== exp[(k < 60) ? k/4 : 15]) begin
        $display("FAIL ignore_tx cycle %0d got %b want %b", k, tx0, exp[(k < 60) ? k/4 : 15]); n_miss++;
      end
      if (busy0) busy_n++;
      if (k == 10) begin
        if0.tx_data = 8'h11;
        if0.tx_valid = 1'b1;
      end
      if (k == 11) if0.tx_valid = 1'b0;
      @(negedge clk);
    end
    n_vec++; if (busy_n != fl) begin $display("FAIL ignore_busy_len got %0d want %0d", busy_n, fl); n_miss++; end
  endtask

  task automatic test_dw5_stop2();
    logic [15:0] exp;
    int busy_n, rdy_low, fl;
    exp = 16'hFFFE;
    fl = 32 + 4 * P;
    busy_n = 0;
    rdy_low = 0;
    @(negedge clk);
    if1.tx_data = 5'h1F;
    if1.tx_valid = 1'b1;
    @(negedge clk);
    if1.tx_valid = 1'b0;
    for (int k = 0; k < fl + 8; k++) begin
      n_vec++;
      if (tx1 !== exp[k/4]) begin $display("FAIL dw5_tx cycle %0d got %b want %b", k, tx1, exp[k/4]); n_miss++; end
      if (busy1) busy_n++;
      if (!if1.tx_ready) rdy_low++;
      @(negedge clk);
    end
    n_vec++; if (busy_n != fl) begin $display("FAIL dw5_busy_len got %0d want %0d", busy_n, fl); n_miss++; end
    n_vec++; if (rdy_low != fl - 1) begin $display("FAIL dw5_ready_low got %0d want %0d", rdy_low, fl - 1); n_miss++; end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [15:0] exp;
    int busy_n;
    for (int p = 0; p < 2; p++) begin
      // 0x07 has three ones: even parity bit 1, odd parity bit 0.
      exp = {6'h3F, (p == 0) ? 1'b1 : 1'b0, 8'h07, 1'b0};
      busy_n = 0;
      @(negedge clk);
      if0.tx_data = 8'h07;
      if0.parity_odd = (p == 1);
      if0.tx_valid = 1'b1;
      @(negedge clk);
      if0.tx_valid = 1'b0;
      for (int k = 0; k < 52; k++) begin
        n_vec++;
        if (tx0 !== exp[k/4]) begin $display("FAIL parity%0d_tx cycle %0d got %b want %b", p, k, tx0, exp[k/4]); n_miss++; end
        if (busy0) busy_n++;
        @(negedge clk);
      end
      n_vec++; if (busy_n != 44) begin $display("FAIL parity%0d_busy_len got %0d want 44", p, busy_n); n_miss++; end
    end
    if0.parity_odd = 1'b0;
  endtask
`endif

  initial begin
    if0.tx_data = '0;
    if0.tx_valid = 1'b0;
    if1.tx_data = '0;
    if1.tx_valid = 1'b0;
`ifdef UART_TX_PARITY_EN
    if0.parity_odd = 1'b0;
    if1.parity_odd = 1'b0;
`endif
    test_reset();
    test_basic(8'hA5, "basic_a5");
    test_back_to_back();
    test_reset_mid_frame();
    test_ignore_busy();
    test_dw5_stop2();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. It serialises one word per frame onto `tx`. Data width, bit period and stop-bit count are configurable, and words are accepted through a valid/ready handshake that allows back-to-back frames. It sits between a byte or word source (CPU register, FIFO) and the serial pin.

Parameters:
- DATA_W, 8, data bits per frame; legal 5..9.
- CLKS_PER_BIT, 4, clk cycles per serial bit; legal >= 2.
- STOP_BITS, 1, stop bits per frame; legal 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_W  word to send; sampled on handshake.
- tx_valid  input  1  source has a word; must hold tx_data stable until accepted.
- tx_ready  output  1  block can accept a word this cycle.
- parity_odd  input  1  0 = even, 1 = odd parity; sampled on handshake. Present only with UART_TX_PARITY_EN.
- tx  output  1  serial line, idle high.
- busy  output  1  frame in progress.

Behaviour:
- Reset (async, active-low):
  - tx=1, busy=0, state IDLE, counters 0.
  - tx_ready=1 as soon as reset is released.
  - Reset mid-frame aborts the frame immediately: tx=1 asynchronously, frame discarded, no partial stop bit.
- tx and busy are registered. tx_ready is combinational: state==IDLE, OR final cycle of the final stop bit.
- Handshake: accept when tx_valid && tx_ready at a rising edge. On that edge:
  - latch tx_data (and parity_odd);
  - tx <= 0 (start bit), busy <= 1, state START.
- tx_valid while tx_ready=0 is ignored; the source holds the word.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Every state except IDLE lasts exactly CLKS_PER_BIT cycles.
  - DATA repeats DATA_W times, LSB first; bit index increments at each bit boundary.
  - STOP repeats STOP_BITS times at tx=1.
- Frame length: F = (1 + DATA_W + P + STOP_BITS) * CLKS_PER_BIT cycles of busy=1, where P=1 with parity, else 0.
- Back-to-back: a handshake in the final stop cycle starts the next start bit on the next edge.
  - No idle cycle between frames; busy stays 1.
  - Without a handshake: busy <= 0, tx stays 1, state IDLE.
- Widths:
  - bit counter is $clog2(CLKS_PER_BIT) bits;
  - bit index is $clog2(DATA_W) bits;
  - counters compare against CLKS_PER_BIT-1 and DATA_W-1, with no reliance on natural wrap.

Optional Feature:
- UART_TX_PARITY_EN defined:
  - PARITY state inserted after DATA, lasting CLKS_PER_BIT cycles.
  - tx = ^data_reg XOR parity_odd_reg.
  - parity_odd port exists.
- Not defined: no PARITY state, no parity_odd port, P=0.

Decomposition:
- Package uart_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - localparam TX_IDLE_LVL=1'b1;
  - function frame_clks(DATA_W, CLKS_PER_BIT, STOP_BITS, P).
- Sub-module uart_baud_cnt (param CLKS_PER_BIT):
  - inputs clk, rst_n, clear, en;
  - output bit_done, pulsing in the last cycle of each bit period.
  - The FSM uses bit_done for all transitions.

Test Plan:
- Defaults, no parity, send 0xA5 → tx = 0, 1,0,1,0,0,1,0,1, 1, each level held 4 cycles. busy high exactly 40 cycles; tx_ready low for 39 cycles.
- UART_TX_PARITY_EN, send 0x07 with parity_odd=0 → parity bit 1; with parity_odd=1 → parity bit 0. Frame is 44 cycles.
- tx_valid held high, send 0x00 then 0xFF → second start bit begins the cycle after the final stop cycle. busy never drops; total 80 cycles.
- Assert rst_n=0 during data bit 3 of 0x5A → tx=1, busy=0 without waiting for a clock edge. After release, 0x3C transmits correctly.
- DATA_W=5, STOP_BITS=2, send 0x1F → 1 start, five 1s, 2 stop bits. busy = 32 cycles.
- Pulse tx_valid with 0x11 mid-frame while tx_ready=0 → ignored; the frame in flight is unchanged and no second frame is sent.
